// File: rtl/movem_pkg.sv
// Shared types and constants for the MOVEM register-transfer sequencer.
package movem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        XFER,
        WB,
        DONE
    } state_t;

    localparam logic DIR_TO_MEM = 1'b0;
    localparam logic DIR_TO_REG = 1'b1;
    localparam int   NUM_DREGS  = 8;

    // Predecrement order walks D7..D0, so the mask is mirrored once at start.
    function automatic logic [NUM_DREGS-1:0] bit_reverse8(input logic [NUM_DREGS-1:0] v);
        logic [NUM_DREGS-1:0] r;
        for (int i = 0; i < NUM_DREGS; i++) begin
            r[i] = v[NUM_DREGS-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/movem_sequencer_if.sv
// Memory-side req/ack bus between the MOVEM sequencer and the bus interface.
interface movem_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/lowest_set_bit8.sv
// Combinational priority encoder: index of the lowest set bit of an 8-bit vector.
module lowest_set_bit8
    import movem_pkg::*;
(
    input  logic [NUM_DREGS-1:0] bits,
    output logic [2:0]           index,
    output logic                 any
);
    always_comb begin
        index = '0;
        any   = |bits;
        for (int i = NUM_DREGS - 1; i >= 0; i--) begin
            if (bits[i]) index = 3'(i);
        end
    end
endmodule

// File: rtl/movem_sequencer.sv
// Walks a register mask, moving one data register per req/ack memory handshake.
module movem_sequencer
    import movem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            mask,
    input  logic                  dir,
    input  logic                  predec,
    output logic [SEL_WIDTH-1:0]  reg_sel_b,
    output logic                  s,
    output logic [DATA_WIDTH-1:0] d,
    input  logic [DATA_WIDTH-1:0] reg_q,
    movem_sequencer_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            xfer_count
);
    state_t     state;
    logic [7:0] pend;
    logic [7:0] pend_next;
    logic       dir_r;
    logic       predec_r;
    logic [2:0] lsb_idx;
    logic       lsb_any;
    logic [2:0] sel_next;

    lowest_set_bit8 u_lsb (
        .bits  (pend),
        .index (lsb_idx),
        .any   (lsb_any)
    );

    // Dropping the lowest set bit is the same as clearing bit p picked in SCAN.
    assign pend_next = pend & (pend - 8'd1);
    assign sel_next  = predec_r ? (3'd7 - lsb_idx) : lsb_idx;

    assign s             = (state == WB) & ~rst;
    assign bus.mem_wdata = bus.mem_req ? reg_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= '0;
            dir_r       <= DIR_TO_MEM;
            predec_r    <= 1'b0;
            reg_sel_b   <= '0;
            d           <= '0;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            xfer_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xfer_count <= '0;
                        if (mask != 8'd0) begin
                            pend     <= predec ? bit_reverse8(mask) : mask;
                            dir_r    <= dir;
                            predec_r <= predec;
                            busy     <= 1'b1;
                            state    <= SCAN;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                SCAN: begin
                    if (lsb_any) begin
                        reg_sel_b   <= SEL_WIDTH'(sel_next);
                        bus.mem_req <= 1'b1;
                        bus.mem_we  <= (dir_r == DIR_TO_MEM);
                        state       <= XFER;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                XFER: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        if (dir_r == DIR_TO_REG) begin
                            d     <= bus.mem_rdata;
                            state <= WB;
                        end else begin
                            pend       <= pend_next;
                            xfer_count <= xfer_count + 4'd1;
                            if (pend_next != 8'd0) begin
                                state <= SCAN;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                end
                WB: begin
                    pend       <= pend_next;
                    xfer_count <= xfer_count + 4'd1;
                    if (pend_next != 8'd0) begin
                        state <= SCAN;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/movem_sequencer.md
Name: movem_sequencer

Overview:
- Sequences multi-register transfers (MOVEM-style) between the 8-entry data register file and the memory bus.
- Walks an 8-bit register mask one register at a time. For each register it drives the file's port-B select and write strobe, and runs a req/ack handshake with memory.
- Sits between the instruction decoder (start/mask/dir) and the data register file plus bus interface.

Parameters:
- DATA_WIDTH, 32, width of register and memory data.
- SEL_WIDTH, 3, register select width (8 registers; fixed for this block).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin transfer; sampled only in IDLE
- mask  in  8  bit n = include Dn; latched on accepted start
- dir  in  1  0 = registers->memory, 1 = memory->registers
- predec  in  1  1 = order D7..D0, 0 = order D0..D7
- reg_sel_b  out  3  register file port-B select
- s  out  1  register file write strobe (port B)
- d  out  32  register file write data
- reg_q  in  32  register file port-B read data (combinational read)
- mem_req  out  1  memory request
- mem_we  out  1  1 = memory write
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory acknowledge
- busy  out  1  high in SCAN/XFER/WB
- done  out  1  one-cycle completion pulse
- xfer_count  out  4  registers transferred so far (0..8)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; reg_sel_b=0, s=0, d=0, mem_req=0, mem_we=0, mem_wdata=0, busy=0, done=0, xfer_count=0; pending mask=0.
- Write-strobe gating: s = (state==WB) & ~rst. A reset asserted during WB suppresses that write.
- IDLE:
  - start & mask!=0: latch mask (bit-reversed if predec), latch dir, clear xfer_count, go SCAN.
  - start & mask==0: go DONE. No mem_req is issued.
- SCAN (1 cycle):
  - Priority encoder picks the lowest set bit p of the pending mask.
  - reg_sel_b <= predec ? 7-p : p. Go XFER.
- XFER:
  - Outputs: mem_req=1, mem_we=~dir, mem_wdata=reg_q (live).
  - reg_sel_b, mem_we and mem_wdata are held stable until mem_ack.
  - On mem_ack with dir=0: clear bit p, xfer_count+1, go SCAN if bits remain, else DONE.
  - On mem_ack with dir=1: d <= mem_rdata, go WB.
- WB (1 cycle): s=1 with the current reg_sel_b; the file captures d at the closing edge. Clear bit p, xfer_count+1, go SCAN or DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE. xfer_count holds until the next accepted start.
- Latency:
  - dir=0: 2 cycles per register with zero-wait ack.
  - dir=1: 3 cycles per register with zero-wait ack.
  - Plus 1 cycle DONE.
- Ignored inputs:
  - start while busy is ignored.
  - mem_ack outside XFER is ignored.
  - mask/dir/predec changes after start are ignored.
- Reset mid-operation from any state: IDLE at the next edge, all outputs return to reset values, no done pulse.
- mask=8'hFF: exactly 8 transfers; xfer_count reaches 8 with no wrap.

Decomposition:
- movem_pkg holds:
  - state enum: IDLE, SCAN, XFER, WB, DONE.
  - constants DIR_TO_MEM=0, DIR_TO_REG=1.
  - NUM_DREGS=8.
- One sub-module: lowest_set_bit8. Combinational 8-bit priority encoder with outputs index[2:0] and any.

Test Plan:
- Reset: rst high 2 cycles mid-random state -> all outputs 0, state IDLE; no s pulse.
- dir=0, predec=0, mask=8'h0A, D1=32'h11111111, D3=32'h33333333, ack 1 cycle after req -> expected:
  - mem_wdata 11111111 (sel 1), then 33333333 (sel 3), mem_we=1.
  - s never 1, xfer_count=2, exactly one done pulse.
- dir=1, predec=1, mask=8'h81, mem_rdata A5A5A5A5 then 5A5A5A5A -> expected:
  - order sel 7 then 0, mem_we=0.
  - Readback D7=A5A5A5A5, D0=5A5A5A5A, other registers unchanged.
- start with mask=0 -> done high on the following cycle; busy, mem_req and s never asserted; xfer_count=0.
- dir=0, mask=8'h04, mem_ack held low 5 cycles -> mem_req, mem_we, reg_sel_b=2 and mem_wdata stable for all 5 cycles. A start pulse during the stall is ignored; exactly 1 transfer completes.
- dir=1, mask=8'h10, D4 preloaded 32'hDEADBEEF, rst asserted during the WB cycle -> D4 still DEADBEEF, state IDLE next cycle, no done pulse.
